mem_c_reader: RTL and testbench
===============================

# mem_c_reader

Result read-out engine for the matrix-multiply datapath. After the multiply controller has filled the 64x64 result memory (rflp4096x22mx4, 22-bit words), this block reads all 4096 entries in row-major order and streams them out on a valid/ready interface. It is the reader at the far end of the result memory and drives the memory's own port set: DO, DIN, RA, CA, NWRT, NCE.

## Interface
Parameters:
- FIFO_DEPTH, 2, output buffer depth; fixed at 2, the minimum for full throughput at 1-cycle read latency
- N_WORDS, 4096, words per dump (64x64)

Ports:
- clk  in  1  single clock; memory CLK is tied to it
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a dump; sampled only in IDLE
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last word is transferred
- mem_ra  out  10  row address = idx[11:2]
- mem_ca  out  2  column address = idx[1:0]
- mem_nce  out  1  active-low chip enable; low only on read-issue cycles
- mem_nwrt  out  1  tied 1 (read only)
- mem_din  out  22  tied 0
- mem_do  in  22  memory read data, valid one cycle after issue
- dout  out  22  result word (FIFO head)
- dout_valid  out  1  FIFO non-empty
- dout_ready  in  1  consumer accepts; transfer = dout_valid & dout_ready
- dout_last  out  1  present only with C_ROW_LAST_EN (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. idx <= 0, busy <= 1.
- RUN issues a read (mem_nce=0, address = idx, idx++) when count + inflight - pop < FIFO_DEPTH. count = FIFO occupancy, inflight = read issued the previous cycle, pop = transfer this cycle.
- RUN -> DRAIN on the cycle idx 4095 is issued.
- DRAIN -> DONE when the FIFO is empty and no read is in flight.
- DONE asserts done for one cycle, clears busy, then goes to IDLE.
- Returned read data is pushed into the FIFO one cycle after issue. Push and pop in the same cycle are legal.
- Order: idx 0..4095 ascending, so row r / column c maps to idx = 64r + c.
- start while busy is ignored. start held high through DONE begins a new dump on the cycle after IDLE is re-entered.
- dout is unchanged while dout_valid=1 and dout_ready=0. No word is ever dropped or duplicated.
- Reset values: busy=0, done=0, dout_valid=0, dout=0, mem_nce=1, mem_ra=0, mem_ca=0, idx=0, FIFO empty, state IDLE.
- Reset mid-dump aborts immediately: mem_nce goes high asynchronously and in-flight data is discarded.

## Timing
- Start sampled at edge k. First issue is in cycle k..k+1, and dout_valid rises after edge k+2.
- With dout_ready held at 1: one word per cycle, 4096 consecutive transfers, no bubbles. done pulses in the cycle after the last transfer. start to done is 4098 cycles.
- Back-pressure: issue stops within one cycle of dout_ready dropping. The FIFO absorbs the in-flight word. Throughput resumes at 1 word/cycle in the cycle after ready returns.

## Configuration
- C_ROW_LAST_EN defined: dout_last port exists and is high with each word whose column = 63 (idx[5:0] = 63), i.e. end of each matrix row. It is carried through the FIFO alongside the data.
- C_ROW_LAST_EN undefined: no dout_last port and no extra FIFO bit. All other behaviour is identical.

## Structure
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE), memory geometry constants (RA width 10, CA width 2, data width 22, N_WORDS 4096, row length 64).
- One sub-module: mem_c_out_fifo, a 2-entry synchronous FIFO with simultaneous push/pop and count output. It is reused for the optional last bit.
- The top holds the FSM, index counter, issue/credit logic and memory port drive.

## Test plan
- Memory preloaded with word[i] = i*3 mod 2^22; start pulse; dout_ready=1 -> 4096 transfers in ascending order, values exact; done at cycle 4098 after start; mem_nwrt never 0.
- Same preload; dout_ready random at 50% -> identical data sequence, no drops or duplicates; FIFO count never exceeds 2; done exactly once.
- dout_ready=0 from word 10 for 20 cycles -> dout holds word 10 stable; at most one extra mem_nce=0 cycle after ready falls; streaming resumes with word 10 then word 11.
- start re-pulsed at word 100 -> ignored, busy stays 1, sequence uninterrupted; rst asserted at word 500 -> all outputs at reset values immediately; next start begins again at idx 0.
- C_ROW_LAST_EN build -> dout_last high exactly on idx 63, 127, ..., 4095 (64 pulses); non-macro build -> compiles without the dout_last port, data sequence identical.

Source files
------------

// File: rtl/mem_c_reader_pkg.sv
// mem_c_reader_pkg: shared definitions for the result-memory read-out engine.
// Holds the FSM state encoding, the 64x64x22 result memory geometry and a
// row-end helper. No ports; imported by mem_c_out_fifo and mem_c_reader.
package mem_c_reader_pkg;

    localparam int RA_W      = 10;
    localparam int CA_W      = 2;
    localparam int DATA_W    = 22;
    localparam int IDX_W     = RA_W + CA_W;
    localparam int MEM_WORDS = 4096;
    localparam int ROW_LEN   = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // True for the word that closes a matrix row (column 63).
    function automatic logic is_row_last(input logic [IDX_W-1:0] idx);
        return idx[5:0] == 6'(ROW_LEN - 1);
    endfunction

endpackage

// File: rtl/mem_c_out_fifo.sv
// mem_c_out_fifo: small synchronous FIFO with simultaneous push/pop.
// Ports: clk, rst (async, active-high), push/din write side, pop read side,
// dout = head word (combinational), count = current occupancy.
module mem_c_out_fifo
    import mem_c_reader_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= nxt(wptr);
            end
            if (do_pop) begin
                rptr <= nxt(rptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/mem_c_reader.sv
// mem_c_reader: streams all 4096 words of the 64x64 result memory in
// row-major order onto a valid/ready port.
// Ports: clk, rst (async, active-high), start, busy, done;
// memory side mem_ra, mem_ca, mem_nce, mem_nwrt, mem_din, mem_do;
// stream side dout, dout_valid, dout_ready and, with macro
// C_ROW_LAST_EN defined, dout_last (high on each row's final word).
module mem_c_reader
    import mem_c_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int N_WORDS    = MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [RA_W-1:0]   mem_ra,
    output logic [CA_W-1:0]   mem_ca,
    output logic              mem_nce,
    output logic              mem_nwrt,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_do,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready
`ifdef C_ROW_LAST_EN
    ,
    output logic              dout_last
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

`ifdef C_ROW_LAST_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             inflight;
    logic             issue;
    logic             pop;
    logic [CW-1:0]    count;
    logic [SW-1:0]    credit;
    logic [FW-1:0]    fifo_din;
    logic [FW-1:0]    fifo_q;

    // Slots already claimed: words held plus the word still in flight.
    assign credit = SW'(count) + SW'(inflight);
    assign pop    = dout_valid && dout_ready;

    // Issue only if the word returning next cycle is sure to fit.
    assign issue  = (state == RUN)
                 && (credit < SW'(FIFO_DEPTH) + SW'(pop));

    assign mem_nce  = !issue;
    assign mem_ra   = idx[IDX_W-1:CA_W];
    assign mem_ca   = idx[CA_W-1:0];
    assign mem_nwrt = 1'b1;
    assign mem_din  = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(N_WORDS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // FIFO empties at this edge and nothing is in flight.
                    if (credit == SW'(pop)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef C_ROW_LAST_EN
    logic last_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_inflight <= 1'b0;
        end else begin
            last_inflight <= issue && is_row_last(idx);
        end
    end

    assign fifo_din  = {last_inflight, mem_do};
    assign dout_last = fifo_q[DATA_W];
`else
    assign fifo_din  = mem_do;
`endif

    assign dout       = fifo_q[DATA_W-1:0];
    assign dout_valid = (count != '0);

    mem_c_out_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_q),
        .count (count)
    );

endmodule

// File: tb/tb_mem_c_reader.sv
// tb_mem_c_reader: self-checking bench for mem_c_reader with a
// behavioural result-memory model and a row-major stream scoreboard.
module tb_mem_c_reader;

    localparam int NW = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dout_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [9:0]  mem_ra;
    logic [1:0]  mem_ca;
    logic        mem_nce;
    logic        mem_nwrt;
    logic [21:0] mem_din;
    logic [21:0] mem_do = '0;
    logic [21:0] dout;
    logic        dout_valid;
`ifdef C_ROW_LAST_EN
    logic        dout_last;
`endif

    always #5 clk = ~clk;

    mem_c_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_ra     (mem_ra),
        .mem_ca     (mem_ca),
        .mem_nce    (mem_nce),
        .mem_nwrt   (mem_nwrt),
        .mem_din    (mem_din),
        .mem_do     (mem_do),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef C_ROW_LAST_EN
        ,
        .dout_last  (dout_last)
`endif
    );

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result memory: one-cycle read latency, preloaded with i*3.
    logic [21:0] marr [NW];
    initial begin
        for (int i = 0; i < NW; i++) begin
            marr[i] = 22'((i * 3) & 32'h3FFFFF);
        end
    end
    always @(posedge clk) begin
        if (!mem_nce && mem_nwrt) begin
            mem_do <= marr[{mem_ra, mem_ca}];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          issued;
    int          xfers;
    int          done_cnt;
    int          done_cyc;
    int          first_valid;
    int          lasts;
    int          hold_issues;
    int          t0;
    bit          hold_win = 1'b0;
    bit          held = 1'b0;
    logic [21:0] held_val;

    // Scoreboard: words must appear as idx 0,1,2,... with value idx*3.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            check("nwrt", 32'(mem_nwrt), 1);
            if (held) begin
                check("hold_stable", 32'(dout), 32'(held_val));
            end
            if (!mem_nce) begin
                check("issue_addr", 32'({mem_ra, mem_ca}), issued);
                issued++;
                if (hold_win) hold_issues++;
            end
            if (dout_valid && first_valid < 0) begin
                first_valid = cyc;
            end
            if (dout_valid && dout_ready) begin
                check("data", 32'(dout), (xfers * 3) & 32'h3FFFFF);
`ifdef C_ROW_LAST_EN
                check("last", 32'(dout_last), 32'((xfers % 64) == 63));
                if ((xfers % 64) == 63) lasts++;
`endif
                xfers++;
            end
            if (!mem_nce) begin
                check("occupancy", 32'((issued - xfers) <= 2), 1);
            end
            held     = dout_valid && !dout_ready;
            held_val = dout;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_sb();
        issued      = 0;
        xfers       = 0;
        done_cnt    = 0;
        done_cyc    = 0;
        first_valid = -1;
        lasts       = 0;
        hold_issues = 0;
    endtask

    task automatic kick();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        check("busy_on", 32'(busy), 1);
    endtask

    task automatic run_until_done(input bit rnd);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            @(posedge clk);
            #1;
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        check("done_timeout", 32'(done_cnt != 0), 1);
    endtask

    task automatic wait_xfers(input int target);
        int n;
        n = 0;
        while (xfers < target && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_word", xfers, target);
    endtask

    task automatic finish_run(input bit timed);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("done_once", done_cnt, 1);
        check("xfer_total", xfers, NW);
        check("issue_total", issued, NW);
        check("busy_off", 32'(busy), 0);
`ifdef C_ROW_LAST_EN
        check("last_total", lasts, 64);
`endif
        if (timed) begin
            check("start_to_done", done_cyc - t0, 4098);
            check("first_valid", first_valid - t0, 2);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_nce", 32'(mem_nce), 1);
        check("rst_ra", 32'(mem_ra), 0);
        check("rst_ca", 32'(mem_ca), 0);
        check("rst_nwrt", 32'(mem_nwrt), 1);
        check("rst_din", 32'(mem_din), 0);
`ifdef C_ROW_LAST_EN
        check("rst_last", 32'(dout_last), 0);
`endif
    endtask

    initial begin
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        // Full throughput.
        clear_sb();
        dout_ready = 1'b1;
        kick();
        run_until_done(1'b0);
        finish_run(1'b1);

        // Random back-pressure.
        clear_sb();
        kick();
        run_until_done(1'b1);
        finish_run(1'b0);

        // Stall at word 10, ignored restart at 100, reset at 500.
        clear_sb();
        dout_ready = 1'b1;
        kick();
        wait_xfers(10);
        dout_ready = 1'b0;
        hold_win   = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("hold_word", 32'(dout), 30);
        check("hold_valid", 32'(dout_valid), 1);
        hold_win   = 1'b0;
        check("hold_issues", 32'(hold_issues <= 1), 1);
        dout_ready = 1'b1;
        wait_xfers(100);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_restart", 32'(busy), 1);
        wait_xfers(500);
        rst = 1'b1;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fresh dump after reset starts again from idx 0.
        clear_sb();
        dout_ready = 1'b1;
        kick();
        run_until_done(1'b0);
        finish_run(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
